// File: rtl/spi_transaction_arbiter_if.sv
// Fabric-side bundle between requesters, the arbiter and the bidirectional_spi transaction ports.
interface spi_transaction_arbiter_if #(
   parameter int unsigned NUM_REQ               = 4,
   parameter int unsigned DATA_WIDTH            = 32,
   parameter int unsigned TRANSACTION_LEN_WIDTH = 8,
   parameter int unsigned ID_W                  = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]                       req_valid;
   logic [NUM_REQ*TRANSACTION_LEN_WIDTH-1:0] req_length;
   logic [NUM_REQ*DATA_WIDTH-1:0]            req_data;
   logic [NUM_REQ*DATA_WIDTH-1:0]            req_rw_mask;
   logic [NUM_REQ-1:0]                       req_ready;
   logic                                     rsp_valid;
   logic [ID_W-1:0]                          rsp_id;
   logic                                     rsp_error;
   logic [DATA_WIDTH-1:0]                    rsp_read_data;
   logic                                     busy;
   logic [TRANSACTION_LEN_WIDTH-1:0]         spi_transaction_length;
   logic [DATA_WIDTH-1:0]                    spi_transaction_data;
   logic [DATA_WIDTH-1:0]                    spi_transaction_rw_mask;
   logic [DATA_WIDTH-1:0]                    spi_transaction_read_data;

   modport slave (
      input  req_valid, req_length, req_data, req_rw_mask, spi_transaction_read_data,
      output req_ready, rsp_valid, rsp_id, rsp_error, rsp_read_data, busy,
             spi_transaction_length, spi_transaction_data, spi_transaction_rw_mask
   );

   modport master (
      output req_valid, req_length, req_data, req_rw_mask, spi_transaction_read_data,
      input  req_ready, rsp_valid, rsp_id, rsp_error, rsp_read_data, busy,
             spi_transaction_length, spi_transaction_data, spi_transaction_rw_mask
   );
endinterface

// File: rtl/spi_transaction_arbiter.sv
// Round-robin arbiter sharing one bidirectional_spi core between NUM_REQ fabric requesters.
// Issues a one-cycle length pulse, waits a computed interval, then returns masked read data.
module spi_transaction_arbiter #(
   parameter int unsigned NUM_REQ               = 4,
   parameter int unsigned DATA_WIDTH            = 32,
   parameter int unsigned TRANSACTION_LEN_WIDTH = 8,
   parameter int unsigned CYCLES_PER_BIT        = 8,
   parameter int unsigned OVERHEAD_CYCLES       = 32,
   parameter int unsigned ID_W                  = $clog2(NUM_REQ)
) (
   input logic                      fabric_clk,
   input logic                      reset_n,
   spi_transaction_arbiter_if.slave bus
);
   localparam int unsigned TLW = TRANSACTION_LEN_WIDTH;
   localparam int unsigned CW  = TLW + 16;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

   state_e                state_q, state_d;
   logic [ID_W-1:0]       last_grant_q, last_grant_d;
   logic [TLW-1:0]        len_q, len_d;
   logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
   logic [NUM_REQ-1:0]    ready_q, ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_error_q, rsp_error_d;
   logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  busy_q, busy_d;
   logic [TLW-1:0]        spi_len_q, spi_len_d;
   logic [DATA_WIDTH-1:0] spi_data_q, spi_data_d;
   logic [DATA_WIDTH-1:0] spi_mask_q, spi_mask_d;

   logic                  found;
   logic [ID_W-1:0]       grant;
   logic [TLW-1:0]        sel_len;
   logic                  len_bad;
   logic [DATA_WIDTH-1:0] len_mask;

   // Scan starts just after the previous winner so nobody is granted twice while others wait.
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         if (!found && bus.req_valid[ID_W'((int'(last_grant_q) + k) % int'(NUM_REQ))]) begin
            found = 1'b1;
            grant = ID_W'((int'(last_grant_q) + k) % int'(NUM_REQ));
         end
      end
   end

   assign sel_len  = bus.req_length[int'(grant)*int'(TLW) +: TLW];
   assign len_bad  = (sel_len == '0) || (32'(sel_len) > DATA_WIDTH);
   assign len_mask = ~({DATA_WIDTH{1'b1}} << len_q);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      len_d        = len_q;
      wait_cnt_d   = wait_cnt_q;
      ready_d      = '0;
      rsp_valid_d  = 1'b0;
      rsp_error_d  = 1'b0;
      rsp_id_d     = '0;
      rsp_data_d   = '0;
      spi_len_d    = '0;
      spi_data_d   = spi_data_q;
      spi_mask_d   = spi_mask_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               last_grant_d   = grant;
               len_d          = sel_len;
               spi_data_d     = bus.req_data[int'(grant)*int'(DATA_WIDTH) +: DATA_WIDTH];
               spi_mask_d     = bus.req_rw_mask[int'(grant)*int'(DATA_WIDTH) +: DATA_WIDTH];
               ready_d[grant] = 1'b1;
               if (len_bad) begin
                  // Rejected: accept and answer in the same cycle, core never sees it.
                  state_d     = StRespond;
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b1;
                  rsp_id_d    = grant;
               end else begin
                  state_d   = StIssue;
                  spi_len_d = sel_len;
               end
            end
         end
         StIssue: begin
            wait_cnt_d = CW'(len_q) * CW'(CYCLES_PER_BIT) + CW'(OVERHEAD_CYCLES);
            state_d    = StWait;
         end
         StWait: begin
            wait_cnt_d = wait_cnt_q - CW'(1);
            if (wait_cnt_d == '0) begin
               state_d     = StRespond;
               rsp_valid_d = 1'b1;
               rsp_id_d    = last_grant_q;
               rsp_data_d  = bus.spi_transaction_read_data & ~spi_mask_q & len_mask;
            end
         end
         StRespond: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge fabric_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         len_q        <= '0;
         wait_cnt_q   <= '0;
         ready_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_error_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         busy_q       <= 1'b0;
         spi_len_q    <= '0;
         spi_data_q   <= '0;
         spi_mask_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         len_q        <= len_d;
         wait_cnt_q   <= wait_cnt_d;
         ready_q      <= ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_error_q  <= rsp_error_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         busy_q       <= busy_d;
         spi_len_q    <= spi_len_d;
         spi_data_q   <= spi_data_d;
         spi_mask_q   <= spi_mask_d;
      end
   end

   assign bus.req_ready               = ready_q;
   assign bus.rsp_valid               = rsp_valid_q;
   assign bus.rsp_id                  = rsp_id_q;
   assign bus.rsp_error               = rsp_error_q;
   assign bus.rsp_read_data           = rsp_data_q;
   assign bus.busy                    = busy_q;
   assign bus.spi_transaction_length  = spi_len_q;
   assign bus.spi_transaction_data    = spi_data_q;
   assign bus.spi_transaction_rw_mask = spi_mask_q;
endmodule

// File: tb/tb_spi_transaction_arbiter.sv
// Directed plus randomized bench for spi_transaction_arbiter against a transaction-level model.
module tb_spi_transaction_arbiter;
   localparam int NR  = 4;
   localparam int DW  = 32;
   localparam int TLW = 8;
   localparam int CPB = 8;
   localparam int OVH = 32;

   logic fabric_clk;
   logic reset_n;
   int   n_total = 0;
   int   n_pass  = 0;
   int   cyc     = 0;
   int   model_last;
   int   t_prev, t_cur, exp_id;

   spi_transaction_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(TLW)) bus ();

   spi_transaction_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(TLW),
      .CYCLES_PER_BIT(CPB), .OVERHEAD_CYCLES(OVH)
   ) dut (
      .fabric_clk(fabric_clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial fabric_clk = 1'b0;
   always #5 fabric_clk = ~fabric_clk;
   always @(posedge fabric_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Round-robin reference: first valid requester after the previous winner, modulo NR.
   function automatic int rr_pick(input int last, input logic [NR-1:0] v);
      for (int k = 1; k <= NR; k++) if (v[(last + k) % NR]) return (last + k) % NR;
      return -1;
   endfunction

   function automatic logic [DW-1:0] exp_rdata(input logic [DW-1:0] rd, input logic [DW-1:0] m,
                                                input int len);
      logic [63:0] full;
      full = ((64'd1 << len) - 64'd1) & {32'd0, rd} & ~{32'd0, m};
      return full[DW-1:0];
   endfunction

   task automatic set_req(input int i, input int len, input logic [DW-1:0] d,
                          input logic [DW-1:0] m);
      bus.req_length[i*TLW +: TLW]  = TLW'(len);
      bus.req_data[i*DW +: DW]      = d;
      bus.req_rw_mask[i*DW +: DW]   = m;
   endtask

   // Follows one granted transaction from accept to response; returns the accept cycle.
   task automatic expect_txn(input string tag, input int id, input int len,
                             input logic [DW-1:0] d, input logic [DW-1:0] m,
                             input logic [DW-1:0] rd, input bit drop,
                             input logic [NR-1:0] add_valid, output int t_ready);
      int  c;
      int  w;
      bit  len_seen;
      bit  rsp_early;
      c = 0;
      while (bus.req_ready == '0 && c < 2000) begin
         @(negedge fabric_clk);
         c++;
      end
      t_ready = cyc;
      check({tag, "_ready_seen"}, 64'(bus.req_ready != '0), 64'd1);
      check({tag, "_ready_onehot"}, 64'($onehot(bus.req_ready)), 64'd1);
      check({tag, "_grant"}, 64'(bus.req_ready), 64'd1 << id);
      model_last = id;
      if (drop) bus.req_valid[id] = 1'b0;
      if (len == 0 || len > DW) begin
         check({tag, "_err_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
         check({tag, "_err_flag"}, 64'(bus.rsp_error), 64'd1);
         check({tag, "_err_id"}, 64'(bus.rsp_id), 64'(id));
         check({tag, "_err_rdata"}, 64'(bus.rsp_read_data), 64'd0);
         check({tag, "_err_len0"}, 64'(bus.spi_transaction_length), 64'd0);
         @(negedge fabric_clk);
         check({tag, "_err_idle"}, {62'd0, bus.busy, bus.rsp_valid}, 64'd0);
         check({tag, "_err_len1"}, 64'(bus.spi_transaction_length), 64'd0);
      end else begin
         check({tag, "_len_pulse"}, 64'(bus.spi_transaction_length), 64'(len));
         check({tag, "_data"}, 64'(bus.spi_transaction_data), 64'(d));
         check({tag, "_mask"}, 64'(bus.spi_transaction_rw_mask), 64'(m));
         bus.spi_transaction_read_data = rd;
         w = len * CPB + OVH;
         len_seen  = 1'b0;
         rsp_early = 1'b0;
         @(negedge fabric_clk);
         c = 1;
         bus.req_valid = bus.req_valid | add_valid;
         while (!bus.rsp_valid && c < w + 100) begin
            if (bus.spi_transaction_length != '0) len_seen = 1'b1;
            @(negedge fabric_clk);
            c++;
         end
         check({tag, "_len_zero_in_wait"}, 64'(len_seen), 64'd0);
         check({tag, "_latency"}, 64'(c), 64'(w + 1));
         check({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(id));
         check({tag, "_rsp_err"}, 64'(bus.rsp_error), 64'd0);
         check({tag, "_rsp_rdata"}, 64'(bus.rsp_read_data), 64'(exp_rdata(rd, m, len)));
         check({tag, "_data_stable"}, 64'(bus.spi_transaction_data), 64'(d));
         @(negedge fabric_clk);
         rsp_early = bus.rsp_valid;
         check({tag, "_rsp_one_cycle"}, 64'(rsp_early), 64'd0);
         check({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
      end
   endtask

   initial begin
      logic [DW-1:0] rd_v, d_v, m_v;
      logic [NR-1:0] v;
      int            lens [NR];
      logic [DW-1:0] ds [NR];
      logic [DW-1:0] ms [NR];
      int            lim;

      reset_n = 1'b0;
      bus.req_valid = '0;
      bus.req_length = '0;
      bus.req_data = '0;
      bus.req_rw_mask = '0;
      bus.spi_transaction_read_data = '0;
      model_last = NR - 1;
      repeat (3) @(negedge fabric_clk);
      check("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.busy,
                              bus.spi_transaction_length}, '0);
      check("reset_rdata", 64'(bus.rsp_read_data), 64'd0);
      reset_n = 1'b1;
      @(negedge fabric_clk);
      check("idle_not_busy", 64'(bus.busy), 64'd0);

      // Write from req0: fully write-masked, so response data is zero.
      rd_v = $urandom;
      set_req(0, 16, 32'h0000_A5A5, 32'h0000_FFFF);
      bus.req_valid = 4'b0001;
      expect_txn("write", rr_pick(model_last, bus.req_valid), 16, 32'h0000_A5A5,
                 32'h0000_FFFF, rd_v, 1'b1, '0, t_cur);

      // Read from req1.
      set_req(1, 16, 32'h0, 32'h0000_FF00);
      bus.req_valid = 4'b0010;
      expect_txn("read", rr_pick(model_last, bus.req_valid), 16, 32'h0, 32'h0000_FF00,
                 32'h0001_2345, 1'b1, '0, t_cur);
      check("read_value", 64'(bus.rsp_read_data), 64'd0);

      // Length errors: zero and one beyond DATA_WIDTH.
      set_req(2, 0, 32'h1234, 32'h0);
      bus.req_valid = 4'b0100;
      expect_txn("err_len0", rr_pick(model_last, bus.req_valid), 0, 32'h1234, 32'h0,
                 32'h0, 1'b1, '0, t_cur);
      set_req(3, 33, 32'h5678, 32'h0);
      bus.req_valid = 4'b1000;
      expect_txn("err_len33", rr_pick(model_last, bus.req_valid), 33, 32'h5678, 32'h0,
                 32'h0, 1'b1, '0, t_cur);

      // Round-robin with everybody continuously valid.
      for (int i = 0; i < NR; i++) set_req(i, 8, 32'(i + 1), 32'h0);
      bus.req_valid = '1;
      t_prev = -1;
      for (int n = 0; n < 5; n++) begin
         exp_id = rr_pick(model_last, bus.req_valid);
         check("rr_order", 64'(exp_id), 64'(n % NR));
         expect_txn("rr", exp_id, 8, 32'(exp_id + 1), 32'h0, $urandom, 1'b0, '0, t_cur);
         if (t_prev >= 0) check("rr_spacing", 64'(t_cur - t_prev), 64'(8 * CPB + OVH + 3));
         t_prev = t_cur;
      end
      bus.req_valid = '0;
      @(negedge fabric_clk);

      // Contention: req0 and req2 arrive during req1's wait.
      set_req(0, 4, 32'hF, 32'h3);
      set_req(1, 12, 32'hABC, 32'h0);
      set_req(2, 20, 32'h0, 32'h0);
      bus.req_valid = 4'b0010;
      expect_txn("cont1", rr_pick(model_last, bus.req_valid), 12, 32'hABC, 32'h0, $urandom,
                 1'b1, 4'b0101, t_cur);
      expect_txn("cont2", rr_pick(model_last, bus.req_valid), 20, 32'h0, 32'h0, $urandom,
                 1'b1, '0, t_cur);
      expect_txn("cont3", rr_pick(model_last, bus.req_valid), 4, 32'hF, 32'h3, 32'hFFFF_FFFF,
                 1'b1, '0, t_cur);

      // Randomized: random valid sets, lengths (some illegal), data, masks and read data.
      for (int n = 0; n < 10; n++) begin
         for (int i = 0; i < NR; i++) begin
            lens[i] = $urandom_range(0, 36);
            ds[i]   = $urandom;
            ms[i]   = $urandom;
            set_req(i, lens[i], ds[i], ms[i]);
         end
         v = NR'($urandom_range(1, (1 << NR) - 1));
         bus.req_valid = v;
         exp_id = rr_pick(model_last, v);
         rd_v = $urandom;
         expect_txn("rand", exp_id, lens[exp_id], ds[exp_id], ms[exp_id], rd_v, 1'b0, '0, t_cur);
         bus.req_valid = '0;
      end

      // Reset in the middle of req3's wait.
      set_req(3, 24, 32'hDEAD, 32'h0);
      bus.req_valid = 4'b1000;
      lim = 0;
      while (bus.req_ready == '0 && lim < 100) begin
         @(negedge fabric_clk);
         lim++;
      end
      check("rst_grant3", 64'(bus.req_ready), 64'b1000);
      bus.req_valid = '0;
      repeat (30) @(negedge fabric_clk);
      check("rst_pre_busy", 64'(bus.busy), 64'd1);
      reset_n = 1'b0;
      #1;
      check("rst_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.busy,
                            bus.spi_transaction_length}, '0);
      check("rst_data", {bus.spi_transaction_data, bus.spi_transaction_rw_mask}, '0);
      model_last = NR - 1;
      lim = 0;
      repeat (3) begin
         @(negedge fabric_clk);
         if (bus.rsp_valid) lim++;
      end
      for (int i = 0; i < NR; i++) set_req(i, 8, 32'(i), 32'h0);
      bus.req_valid = '1;
      reset_n = 1'b1;
      repeat (300) begin
         @(negedge fabric_clk);
         if (bus.rsp_valid && bus.req_ready == '0) lim++;
         if (bus.req_ready != '0) break;
      end
      check("rst_no_stale_rsp", 64'(lim), 64'd0);
      expect_txn("post_rst", rr_pick(model_last, bus.req_valid), 8, 32'h0, 32'h0, $urandom,
                 1'b1, '0, t_cur);
      check("post_rst_first_is_0", 64'(model_last), 64'd0);
      bus.req_valid = '0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
